sdram_auto_refresh: RTL and testbench
=====================================

SDRAM_AUTO_REFRESH -- requirements
Module: sdram_auto_refresh

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- CLK, 100_000_000, clock frequency in Hz.
- TRP, 20, tRP in ns.
- TRFC, 70, tRFC in ns.
- TREFI, 7500, refresh request interval in ns.
- AUTO_REF_COUNT, 2, AUTO_REF commands per refresh sequence; legal range 1~7.
REQ-002 Derived cycle counts SHALL use integer division:
- CLK_TRP = TRP/(1e9/CLK); default 2.
- CLK_TRFC = TRFC/(1e9/CLK); default 7.
- CLK_REFI = TREFI/(1e9/CLK); default 750.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- init_end  input  1  SDRAM initialization complete, level.
- ref_en  input  1  refresh grant from arbiter.
- ref_req  output  1  refresh request to arbiter, level.
- ref_end  output  1  refresh sequence complete, 1-cycle pulse.
- cmd  output  4  SDRAM command {CS_n,RAS_n,CAS_n,WE_n}.
- ba  output  2  bank address.
- addr  output  13  address bus.
REQ-004 Command encodings SHALL be `OP_NOP=4'b0111, `OP_PRECHARGE=4'b0010, `OP_AUTO_REF=4'b0001, taken from sdram_op.v.
REQ-005 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Function
REQ-006 Interval counter (10 bits) SHALL:
- hold at 0 while init_end=0;
- increment on each cycle with init_end=1;
- wrap to 0 after reaching CLK_REFI-1;
- keep counting during refresh sequences.
REQ-007 Request handshake:
- ref_req SHALL go to 1 on the edge where the interval counter wraps.
- ref_req SHALL clear on the edge where state=IDLE, ref_req=1 and ref_en=1 (grant accepted).
- If a wrap and a grant occur on the same edge, ref_req SHALL remain 1 and the sequence SHALL start.
- ref_en while ref_req=0 or state≠IDLE SHALL be ignored.
REQ-008 init_end falling to 0 SHALL clear ref_req and the interval counter; a sequence already in progress SHALL run to completion.
REQ-009 States SHALL be IDLE, PRECHARGE, PRECHARGE_WAIT, AUTO_REF, AUTO_REF_WAIT, DONE.
REQ-010 State transitions SHALL be:
- IDLE→PRECHARGE on accepted grant.
- PRECHARGE→PRECHARGE_WAIT after one cycle.
- PRECHARGE_WAIT→AUTO_REF after CLK_TRP cycles.
- AUTO_REF→AUTO_REF_WAIT after one cycle.
- AUTO_REF_WAIT→AUTO_REF after CLK_TRFC cycles if fewer than AUTO_REF_COUNT AUTO_REFs have been issued; otherwise →DONE.
- DONE→IDLE after one cycle.
REQ-011 Wait counter (8 bits) SHALL reset to 0 on entering each *_WAIT state and compare against N-1; the AUTO_REF counter (3 bits) SHALL clear on entering PRECHARGE.
REQ-012 Command output SHALL lag state by exactly one cycle:
- cmd=`OP_PRECHARGE for one cycle after PRECHARGE, with ba=2'b11 and addr=13'h1fff (A10=1, all banks).
- cmd=`OP_AUTO_REF for one cycle after each AUTO_REF, with ba=2'b11 and addr=13'h1fff.
- Otherwise cmd=`OP_NOP, ba=2'b11, addr=13'h1fff.
REQ-013 ref_end SHALL be 1 for exactly the cycle after state=DONE, and 0 otherwise.
REQ-014 Defaults, with the grant sampled at edge E0:
- PRECHARGE cmd valid after E1.
- AUTO_REF cmds valid after E4 and E12.
- ref_end high after E20.
- State back at IDLE after E20, ready to accept the next grant at E21.
REQ-015 Spacing: PRECHARGE→first AUTO_REF SHALL be ≥CLK_TRP+1 cycles; AUTO_REF→AUTO_REF and last AUTO_REF→ref_end SHALL be ≥CLK_TRFC+1 cycles.

Reset
REQ-016 When rst=1 at a rising edge, the following SHALL hold after that edge:
- state=IDLE; all counters 0;
- ref_req=0, ref_end=0;
- cmd=`OP_NOP, ba=2'b11, addr=13'h1fff.
REQ-017 rst asserted mid-sequence SHALL abort the sequence on that edge with no further PRECHARGE or AUTO_REF issued; normal operation SHALL resume only after init_end is again sampled high.

Verification
REQ-018 Benches SHALL cover these directed scenarios (defaults):
- rst 3 cycles, init_end=0 for 2000 cycles -> ref_req=0, cmd=4'b0111 throughout.
- init_end rises -> ref_req rises exactly 750 cycles later; repeats every 750 cycles.
- ref_req=1, ref_en pulse at E0 -> 4'b0010 after E1, 4'b0001 after E4 and E12, ref_end single pulse after E20, ref_req low after E0.
- ref_en held low 1600 cycles -> ref_req stays 1, no command issued; grant then yields exactly one sequence.
- Counter wrap on the same edge as the grant -> sequence starts and ref_req stays 1.
- rst during AUTO_REF_WAIT -> cmd=NOP next cycle, no ref_end, ref_req=0.
- AUTO_REF_COUNT=4 -> four 4'b0001 commands spaced 8 cycles apart.

Source files
------------

// File: rtl/sdram_auto_refresh.sv
// -----------------------------------------------------------------------------
// sdram_auto_refresh
//
// Periodic SDRAM auto-refresh engine. An interval counter raises a refresh
// request to the memory arbiter once per refresh interval. When the arbiter
// grants the request, the engine issues PRECHARGE-ALL, waits tRP, then issues
// AUTO_REF_COUNT AUTO_REFRESH commands, each followed by a tRFC wait. Finally
// it signals completion with a one-cycle ref_end pulse.
//
// Ports
//   clk       in   1   single clock, all logic on its rising edge
//   rst       in   1   synchronous, active-high reset
//   init_end  in   1   SDRAM power-up initialization complete (level)
//   ref_en    in   1   refresh grant from the arbiter
//   ref_req   out  1   refresh request to the arbiter (level)
//   ref_end   out  1   refresh sequence complete (1-cycle pulse)
//   cmd       out  4   SDRAM command {CS_n, RAS_n, CAS_n, WE_n}
//   ba        out  2   bank address
//   addr      out  13  address bus (A10 high selects all banks)
//
// All outputs come straight from flops; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module sdram_auto_refresh #(
    parameter int CLK            = 100_000_000, // clock frequency, Hz
    parameter int TRP            = 20,          // tRP, ns
    parameter int TRFC           = 70,          // tRFC, ns
    parameter int TREFI          = 7500,        // refresh request interval, ns
    parameter int AUTO_REF_COUNT = 2            // AUTO_REFs per sequence, 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_end,
    input  logic        ref_en,
    output logic        ref_req,
    output logic        ref_end,
    output logic [3:0]  cmd,
    output logic [1:0]  ba,
    output logic [12:0] addr
);

    // SDRAM command encodings {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] OP_NOP       = 4'b0111;
    localparam logic [3:0] OP_PRECHARGE = 4'b0010;
    localparam logic [3:0] OP_AUTO_REF  = 4'b0001;

    // Bank/address values driven during refresh: all banks, A10 high.
    localparam logic [1:0]  BA_ALL   = 2'b11;
    localparam logic [12:0] ADDR_ALL = 13'h1fff;

    // Timing in clock cycles, truncated by integer division.
    localparam int NS_PER_CLK = 1_000_000_000 / CLK;
    localparam int CLK_TRP    = TRP / NS_PER_CLK;
    localparam int CLK_TRFC   = TRFC / NS_PER_CLK;
    localparam int CLK_REFI   = TREFI / NS_PER_CLK;

    // Terminal values for the counters (counters run 0..N-1).
    localparam logic [7:0] TRP_LAST   = 8'(CLK_TRP - 1);
    localparam logic [7:0] TRFC_LAST  = 8'(CLK_TRFC - 1);
    localparam logic [9:0] REFI_LAST  = 10'(CLK_REFI - 1);
    localparam logic [2:0] REF_NUM    = 3'(AUTO_REF_COUNT);

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRECHARGE      = 3'd1,
        PRECHARGE_WAIT = 3'd2,
        AUTO_REF       = 3'd3,
        AUTO_REF_WAIT  = 3'd4,
        DONE           = 3'd5
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [9:0]   r_refi_cnt;   // refresh interval counter
    logic [7:0]   r_wait_cnt;   // cycles spent in the current *_WAIT state
    logic [2:0]   r_ref_cnt;    // AUTO_REF commands issued this sequence

    logic         r_ref_req;
    logic         r_ref_end;
    logic [3:0]   r_cmd;
    logic [1:0]   r_ba;
    logic [12:0]  r_addr;

    logic         w_refi_wrap;
    logic         w_grant;
    logic         w_trp_done;
    logic         w_trfc_done;
    logic [3:0]   w_cmd_nxt;
    logic         w_ref_end_nxt;

    // -------------------------------------------------------------------------
    // Request/grant handshake:
    //   ref_req is a level that rises on the edge where the interval counter
    //   wraps and stays high until the arbiter grants it. A grant is accepted
    //   only on an edge where the FSM is IDLE and ref_req is already high;
    //   ref_en at any other time is ignored. Accepting the grant clears
    //   ref_req, unless the interval counter wraps on that same edge, in which
    //   case the new interval's request wins and ref_req stays high while the
    //   sequence starts. Dropping init_end withdraws any pending request.
    // -------------------------------------------------------------------------
    assign w_refi_wrap = init_end && (r_refi_cnt == REFI_LAST);
    assign w_grant     = (r_state == IDLE) && r_ref_req && ref_en;
    assign w_trp_done  = (r_wait_cnt == TRP_LAST);
    assign w_trfc_done = (r_wait_cnt == TRFC_LAST);

    // Interval counter: free-runs while initialization is complete, including
    // during refresh sequences, so the request period stays fixed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refi_cnt <= '0;
        end else if (!init_end || w_refi_wrap) begin
            r_refi_cnt <= '0;
        end else begin
            r_refi_cnt <= r_refi_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_req <= 1'b0;
        end else if (!init_end) begin
            r_ref_req <= 1'b0;
        end else if (w_refi_wrap) begin
            r_ref_req <= 1'b1;
        end else if (w_grant) begin
            r_ref_req <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = PRECHARGE;
                end
            end
            PRECHARGE: begin
                w_state_nxt = PRECHARGE_WAIT;
            end
            PRECHARGE_WAIT: begin
                if (w_trp_done) begin
                    w_state_nxt = AUTO_REF;
                end
            end
            AUTO_REF: begin
                w_state_nxt = AUTO_REF_WAIT;
            end
            AUTO_REF_WAIT: begin
                // r_ref_cnt already includes the AUTO_REF just issued.
                if (w_trfc_done) begin
                    if (r_ref_cnt < REF_NUM) begin
                        w_state_nxt = AUTO_REF;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Wait counter: zero outside the wait states, so it is always zero on
    // entry to a *_WAIT state; it also returns to zero on the exit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if ((r_state == PRECHARGE_WAIT && !w_trp_done) ||
                     (r_state == AUTO_REF_WAIT  && !w_trfc_done)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // AUTO_REF counter: cleared on the edge that enters PRECHARGE, bumped
    // once per AUTO_REF state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt <= '0;
        end else if (w_grant) begin
            r_ref_cnt <= '0;
        end else if (r_state == AUTO_REF) begin
            r_ref_cnt <= r_ref_cnt + 3'd1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic. Outputs are decoded from the current state and then
    // registered, so the command bus lags the state by one cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        w_cmd_nxt     = OP_NOP;
        w_ref_end_nxt = 1'b0;
        case (r_state)
            PRECHARGE: w_cmd_nxt     = OP_PRECHARGE;
            AUTO_REF:  w_cmd_nxt     = OP_AUTO_REF;
            DONE:      w_ref_end_nxt = 1'b1;
            default:   w_cmd_nxt     = OP_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd     <= OP_NOP;
            r_ref_end <= 1'b0;
            r_ba      <= BA_ALL;
            r_addr    <= ADDR_ALL;
        end else begin
            r_cmd     <= w_cmd_nxt;
            r_ref_end <= w_ref_end_nxt;
            r_ba      <= BA_ALL;
            r_addr    <= ADDR_ALL;
        end
    end

    assign ref_req = r_ref_req;
    assign ref_end = r_ref_end;
    assign cmd     = r_cmd;
    assign ba      = r_ba;
    assign addr    = r_addr;

endmodule

// File: tb/tb_sdram_auto_refresh.sv
// -----------------------------------------------------------------------------
// tb_sdram_auto_refresh
//
// Directed bench for sdram_auto_refresh. Two instances share clk/rst: one with
// default parameters and one with AUTO_REF_COUNT=4. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point, i.e. they show
// the values registered by the edge just passed. Edge E0 is the edge that
// samples the grant.
// -----------------------------------------------------------------------------
module tb_sdram_auto_refresh;

    localparam logic [3:0]  NOP      = 4'b0111;
    localparam logic [3:0]  PRE      = 4'b0010;
    localparam logic [3:0]  AR       = 4'b0001;
    localparam logic [1:0]  BA_ALL   = 2'b11;
    localparam logic [12:0] ADDR_ALL = 13'h1fff;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, init_end, ref_en, init_end4, ref_en4;
    logic ref_req, ref_end, ref_req_4, ref_end_4;
    logic [3:0]  cmd, cmd_4;
    logic [1:0]  ba, ba_4;
    logic [12:0] addr, addr_4;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    int t_rise  = 0;

    sdram_auto_refresh dut (
        .clk(clk), .rst(rst), .init_end(init_end), .ref_en(ref_en),
        .ref_req(ref_req), .ref_end(ref_end), .cmd(cmd), .ba(ba), .addr(addr)
    );

    sdram_auto_refresh #(.AUTO_REF_COUNT(4)) dut4 (
        .clk(clk), .rst(rst), .init_end(init_end4), .ref_en(ref_en4),
        .ref_req(ref_req_4), .ref_end(ref_end_4), .cmd(cmd_4), .ba(ba_4),
        .addr(addr_4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int bad;
        rst = 1'b1; init_end = 1'b0; ref_en = 1'b0;
        init_end4 = 1'b0; ref_en4 = 1'b0;
        repeat (3) tick();
        n_total++; if (ref_req !== 1'b0) $display("FAIL reset_ref_req: got %b want 0", ref_req); else n_pass++;
        n_total++; if (ref_end !== 1'b0) $display("FAIL reset_ref_end: got %b want 0", ref_end); else n_pass++;
        n_total++; if (cmd !== NOP) $display("FAIL reset_cmd: got %b want %b", cmd, NOP); else n_pass++;
        n_total++; if (ba !== BA_ALL) $display("FAIL reset_ba: got %b want %b", ba, BA_ALL); else n_pass++;
        n_total++; if (addr !== ADDR_ALL) $display("FAIL reset_addr: got %h want %h", addr, ADDR_ALL); else n_pass++;
        rst = 1'b0;
        bad = 0;
        repeat (2000) begin
            tick();
            if (ref_req !== 1'b0 || cmd !== NOP || ref_end !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL no_init_idle: got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_interval();
        int t0;
        bit found;
        init_end = 1'b1;
        t0 = cyc;
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (ref_req === 1'b1) begin found = 1'b1; break; end
        end
        n_total++; if (!found) $display("FAIL interval_first_seen: got timeout want ref_req"); else n_pass++;
        n_total++; if (cyc - t0 != 750) $display("FAIL interval_first: got %0d cycles want 750", cyc - t0); else n_pass++;
        t_rise = cyc;
    endtask

    task automatic test_sequence();
        logic [3:0] exp_c;
        logic exp_e;
        bit found;
        ref_en = 1'b1;
        tick();                               // E0
        ref_en = 1'b0;
        n_total++; if (ref_req !== 1'b0) $display("FAIL seq_req_clear: got %b want 0", ref_req); else n_pass++;
        n_total++; if (cmd !== NOP) $display("FAIL seq_cmd_e0: got %b want %b", cmd, NOP); else n_pass++;
        for (int e = 1; e <= 21; e++) begin
            tick();
            exp_c = (e == 1) ? PRE : ((e == 4 || e == 12) ? AR : NOP);
            exp_e = (e == 20);
            n_total++; if (cmd !== exp_c) $display("FAIL seq_cmd_e%0d: got %b want %b", e, cmd, exp_c); else n_pass++;
            n_total++; if (ref_end !== exp_e) $display("FAIL seq_end_e%0d: got %b want %b", e, ref_end, exp_e); else n_pass++;
            if (e == 1) begin
                n_total++; if (ba !== BA_ALL) $display("FAIL seq_ba: got %b want %b", ba, BA_ALL); else n_pass++;
                n_total++; if (addr !== ADDR_ALL) $display("FAIL seq_addr: got %h want %h", addr, ADDR_ALL); else n_pass++;
            end
        end
        found = 1'b0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (ref_req === 1'b1) begin found = 1'b1; break; end
        end
        n_total++; if (!found) $display("FAIL interval_repeat_seen: got timeout want ref_req"); else n_pass++;
        n_total++; if (cyc != t_rise + 750) $display("FAIL interval_repeat: got %0d cycles want 750", cyc - t_rise); else n_pass++;
        t_rise = cyc;
    endtask

    task automatic test_hold_off();
        int bad, n_pre, n_ar, n_end;
        bad = 0;
        repeat (1600) begin
            tick();
            if (ref_req !== 1'b1 || cmd !== NOP || ref_end !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL hold_off_idle: got %0d bad cycles want 0", bad); else n_pass++;
        ref_en = 1'b1;
        tick();
        ref_en = 1'b0;
        n_total++; if (ref_req !== 1'b0) $display("FAIL hold_off_req_clear: got %b want 0", ref_req); else n_pass++;
        n_pre = 0; n_ar = 0; n_end = 0;
        repeat (30) begin
            tick();
            if (cmd === PRE) n_pre++;
            if (cmd === AR) n_ar++;
            if (ref_end === 1'b1) n_end++;
        end
        n_total++; if (n_pre != 1) $display("FAIL hold_off_pre: got %0d want 1", n_pre); else n_pass++;
        n_total++; if (n_ar != 2) $display("FAIL hold_off_ar: got %0d want 2", n_ar); else n_pass++;
        n_total++; if (n_end != 1) $display("FAIL hold_off_end: got %0d want 1", n_end); else n_pass++;
    endtask

    task automatic test_wrap_grant();
        int target, n_ar, n_end;
        target = t_rise + 3000;               // a wrap edge, request pending since t_rise+2250
        for (int i = 0; i < 3000 && cyc < target - 1; i++) tick();
        n_total++; if (cyc != target - 1) $display("FAIL wg_reach: got cycle %0d want %0d", cyc, target - 1); else n_pass++;
        n_total++; if (ref_req !== 1'b1) $display("FAIL wg_req_pending: got %b want 1", ref_req); else n_pass++;
        ref_en = 1'b1;
        tick();                               // E0 coincides with wrap
        ref_en = 1'b0;
        n_total++; if (ref_req !== 1'b1) $display("FAIL wg_req_kept: got %b want 1", ref_req); else n_pass++;
        tick();
        n_total++; if (cmd !== PRE) $display("FAIL wg_pre: got %b want %b", cmd, PRE); else n_pass++;
        n_ar = 0; n_end = 0;
        repeat (20) begin
            tick();
            if (cmd === AR) n_ar++;
            if (ref_end === 1'b1) n_end++;
        end
        n_total++; if (n_ar != 2) $display("FAIL wg_ar: got %0d want 2", n_ar); else n_pass++;
        n_total++; if (n_end != 1) $display("FAIL wg_end: got %0d want 1", n_end); else n_pass++;
        n_total++; if (ref_req !== 1'b1) $display("FAIL wg_req_after: got %b want 1", ref_req); else n_pass++;
    endtask

    task automatic test_rst_mid();
        int bad, t0;
        bit found;
        ref_en = 1'b1;
        tick();                               // E0
        ref_en = 1'b0;
        repeat (4) tick();                    // E4
        n_total++; if (cmd !== AR) $display("FAIL rst_mid_ar1: got %b want %b", cmd, AR); else n_pass++;
        tick();                               // E5, in AUTO_REF_WAIT
        rst = 1'b1;
        tick();                               // E6 samples reset
        rst = 1'b0;
        t0 = cyc;
        n_total++; if (cmd !== NOP) $display("FAIL rst_mid_cmd: got %b want %b", cmd, NOP); else n_pass++;
        n_total++; if (ref_end !== 1'b0) $display("FAIL rst_mid_end: got %b want 0", ref_end); else n_pass++;
        n_total++; if (ref_req !== 1'b0) $display("FAIL rst_mid_req: got %b want 0", ref_req); else n_pass++;
        bad = 0;
        repeat (30) begin
            tick();
            if (cmd !== NOP || ref_end !== 1'b0 || ref_req !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL rst_mid_quiet: got %0d bad cycles want 0", bad); else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (ref_req === 1'b1) begin found = 1'b1; break; end
        end
        n_total++; if (!found) $display("FAIL rst_mid_rise_seen: got timeout want ref_req"); else n_pass++;
        n_total++; if (cyc != t0 + 750) $display("FAIL rst_mid_rise: got %0d cycles want 750", cyc - t0); else n_pass++;
    endtask

    task automatic test_init_drop();
        int t0, n_ar, n_end, end_e, bad;
        bit found;
        init_end = 1'b0;
        tick();
        t0 = cyc;
        n_total++; if (ref_req !== 1'b0) $display("FAIL drop_req_clear: got %b want 0", ref_req); else n_pass++;
        init_end = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (ref_req === 1'b1) begin found = 1'b1; break; end
        end
        n_total++; if (!found) $display("FAIL drop_rise_seen: got timeout want ref_req"); else n_pass++;
        n_total++; if (cyc != t0 + 750) $display("FAIL drop_rise: got %0d cycles want 750", cyc - t0); else n_pass++;
        ref_en = 1'b1;
        tick();                               // E0
        ref_en = 1'b0;
        tick();                               // E1
        n_total++; if (cmd !== PRE) $display("FAIL drop_pre: got %b want %b", cmd, PRE); else n_pass++;
        tick();                               // E2
        init_end = 1'b0;                      // sampled at E3, mid-sequence
        n_ar = 0; n_end = 0; end_e = 0;
        for (int e = 3; e <= 21; e++) begin
            tick();
            if (cmd === AR) n_ar++;
            if (ref_end === 1'b1) begin n_end++; end_e = e; end
        end
        n_total++; if (n_ar != 2) $display("FAIL drop_seq_ar: got %0d want 2", n_ar); else n_pass++;
        n_total++; if (n_end != 1 || end_e != 20) $display("FAIL drop_seq_end: got %0d pulses at E%0d want 1 at E20", n_end, end_e); else n_pass++;
        bad = 0;
        repeat (800) begin
            tick();
            if (ref_req !== 1'b0 || cmd !== NOP) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL drop_idle: got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_count4();
        int t0;
        bit found;
        logic [3:0] exp_c;
        logic exp_e;
        init_end4 = 1'b1;
        t0 = cyc;
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (ref_req_4 === 1'b1) begin found = 1'b1; break; end
        end
        n_total++; if (!found) $display("FAIL c4_rise_seen: got timeout want ref_req"); else n_pass++;
        n_total++; if (cyc != t0 + 750) $display("FAIL c4_rise: got %0d cycles want 750", cyc - t0); else n_pass++;
        ref_en4 = 1'b1;
        tick();                               // E0
        ref_en4 = 1'b0;
        n_total++; if (ref_req_4 !== 1'b0) $display("FAIL c4_req_clear: got %b want 0", ref_req_4); else n_pass++;
        for (int e = 1; e <= 40; e++) begin
            tick();
            exp_c = (e == 1) ? PRE : ((e == 4 || e == 12 || e == 20 || e == 28) ? AR : NOP);
            exp_e = (e == 36);
            n_total++; if (cmd_4 !== exp_c) $display("FAIL c4_cmd_e%0d: got %b want %b", e, cmd_4, exp_c); else n_pass++;
            n_total++; if (ref_end_4 !== exp_e) $display("FAIL c4_end_e%0d: got %b want %b", e, ref_end_4, exp_e); else n_pass++;
        end
        n_total++; if (ba_4 !== BA_ALL) $display("FAIL c4_ba: got %b want %b", ba_4, BA_ALL); else n_pass++;
        n_total++; if (addr_4 !== ADDR_ALL) $display("FAIL c4_addr: got %h want %h", addr_4, ADDR_ALL); else n_pass++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_interval();
        test_sequence();
        test_hold_off();
        test_wrap_grant();
        test_rst_mid();
        test_init_drop();
        test_count4();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit want end of tests");
        $fatal(1, "watchdog expired");
    end

endmodule
